// File: rtl/neuron_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : neuron_output_collector
// Purpose  : Adds bias (+optional ReLU) to accumulator sums and packs them
//            into an output vector handed downstream via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_output_collector #(
  parameter int N           = 32,
  parameter int Q           = 15,
  parameter int MAX_NEURONS = 16,
  parameter int RELU_EN     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(MAX_NEURONS+1)-1:0]   num_neurons,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N-1:0]                       in_sum,
  input  logic [N-1:0]                       in_bias,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [MAX_NEURONS*N-1:0]           out_vec,
  output logic [$clog2(MAX_NEURONS+1)-1:0]   out_count,
  output logic                               busy,
  output logic                               sat_flag
);

  localparam int CW = $clog2(MAX_NEURONS+1);

  if (Q > N - 1) begin : g_q_check
    $error("Q must not exceed the magnitude width N-1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            target_q, target_d;
  logic [CW-1:0]            count_q, count_d;
  logic [MAX_NEURONS*N-1:0] vec_q, vec_d;
  logic                     sat_q, sat_d;

  logic          w_a_sgn, w_b_sgn, w_r_sgn, w_sat;
  logic [N-2:0]  w_a_mag, w_b_mag, w_r_mag;
  logic [N-1:0]  w_mag_sum, w_res;
  logic [CW-1:0] w_count_inc;

  assign w_a_sgn     = in_sum[N-1];
  assign w_a_mag     = in_sum[N-2:0];
  assign w_b_sgn     = in_bias[N-1];
  assign w_b_mag     = in_bias[N-2:0];
  assign w_count_inc = count_q + 1'b1;

  // Sign-magnitude add; the carry out of the magnitude sum flags saturation.
  always_comb begin
    w_mag_sum = {1'b0, w_a_mag} + {1'b0, w_b_mag};
    w_sat     = 1'b0;
    w_r_sgn   = w_a_sgn;
    w_r_mag   = '0;
    if (w_a_sgn == w_b_sgn) begin
      if (w_mag_sum[N-1]) begin
        w_r_mag = '1;
        w_sat   = 1'b1;
      end else begin
        w_r_mag = w_mag_sum[N-2:0];
      end
    end else if (w_a_mag >= w_b_mag) begin
      w_r_mag = w_a_mag - w_b_mag;
    end else begin
      w_r_mag = w_b_mag - w_a_mag;
      w_r_sgn = w_b_sgn;
    end
    if (w_r_mag == '0) w_r_sgn = 1'b0;
    w_res = ((RELU_EN != 0) && w_r_sgn) ? '0 : {w_r_sgn, w_r_mag};
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    vec_d    = vec_q;
    sat_d    = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_neurons == '0 || num_neurons > CW'(MAX_NEURONS))
            target_d = CW'(MAX_NEURONS);
          else
            target_d = num_neurons;
          vec_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          for (int k = 0; k < MAX_NEURONS; k++) begin
            if (count_q == CW'(k)) vec_d[k*N +: N] = w_res;
          end
          count_d = w_count_inc;
          if (w_sat) sat_d = 1'b1;
          if (w_count_inc == target_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      count_q  <= '0;
      vec_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      vec_q    <= vec_d;
      sat_q    <= sat_d;
    end
  end

  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_vec   = vec_q;
  assign out_count = count_q;
  assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_output_collector
// Purpose  : Directed self-checking bench; one instance with ReLU, one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_output_collector;

  localparam int N  = 32;
  localparam int MN = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [CW-1:0] num_neurons;
  logic [N-1:0]  in_sum, in_bias;

  logic          in_ready, out_valid, busy, sat_flag;
  logic [MN*N-1:0] out_vec;
  logic [CW-1:0] out_count;

  logic          nr_in_ready, nr_out_valid, nr_busy, nr_sat_flag;
  logic [MN*N-1:0] nr_out_vec;
  logic [CW-1:0] nr_out_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  neuron_output_collector #(.N(N), .Q(15), .MAX_NEURONS(MN), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_count(out_count), .busy(busy), .sat_flag(sat_flag)
  );

  neuron_output_collector #(.N(N), .Q(15), .MAX_NEURONS(MN), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
    .in_valid(in_valid), .in_ready(nr_in_ready), .in_sum(in_sum), .in_bias(in_bias),
    .out_valid(nr_out_valid), .out_ready(out_ready), .out_vec(nr_out_vec),
    .out_count(nr_out_count), .busy(nr_busy), .sat_flag(nr_sat_flag)
  );

  function automatic logic [N-1:0] lane(input logic [MN*N-1:0] v, input int k);
    return v[k*N +: N];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start = 1'b1;
    num_neurons = n;
    step();
    start = 1'b0;
  endtask

  task automatic xfer(input logic [N-1:0] s, input logic [N-1:0] b);
    in_valid = 1'b1;
    in_sum = s;
    in_bias = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_neurons = '0; in_valid = 1'b0;
    in_sum = '0; in_bias = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, busy, sat_flag, out_count} !== 9'd0) $display("FAIL reset_ctrl: got %b want 0", {out_valid, in_ready, busy, sat_flag, out_count});
    else pass_cnt++;
    total_cnt++;
    if (out_vec !== '0) $display("FAIL reset_vec: got %h want 0", out_vec);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_start(5'd3);
    total_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_count !== 5'd0) $display("FAIL basic_start: busy=%b rdy=%b cnt=%0d want 1 1 0", busy, in_ready, out_count);
    else pass_cnt++;
    xfer(32'h00010000, 32'h00004000);
    total_cnt++;
    if (out_count !== 5'd1) $display("FAIL basic_cnt1: got %0d want 1", out_count);
    else pass_cnt++;
    xfer(32'h00008000, 32'h80010000);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid);
    else pass_cnt++;
    xfer(32'h80018000, 32'h00008000);
    total_cnt++;
    if (out_valid !== 1'b1 || out_count !== 5'd3 || in_ready !== 1'b0) $display("FAIL basic_done: valid=%b cnt=%0d rdy=%b want 1 3 0", out_valid, out_count, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (lane(out_vec, 0) !== 32'h00014000 || lane(out_vec, 1) !== 32'h0 || lane(out_vec, 2) !== 32'h0) $display("FAIL basic_relu_lanes: got %h %h %h want 00014000 0 0", lane(out_vec, 0), lane(out_vec, 1), lane(out_vec, 2));
    else pass_cnt++;
    total_cnt++;
    if (out_vec[MN*N-1:3*N] !== '0) $display("FAIL basic_upper_lanes: got %h want 0", out_vec[MN*N-1:3*N]);
    else pass_cnt++;
    total_cnt++;
    if (lane(nr_out_vec, 0) !== 32'h00014000 || lane(nr_out_vec, 1) !== 32'h80008000 || lane(nr_out_vec, 2) !== 32'h80010000) $display("FAIL basic_norelu_lanes: got %h %h %h want 00014000 80008000 80010000", lane(nr_out_vec, 0), lane(nr_out_vec, 1), lane(nr_out_vec, 2));
    else pass_cnt++;
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      num_neurons = 5'd1;
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 5'd3 || lane(out_vec, 0) !== 32'h00014000 || out_vec[MN*N-1:N] !== '0) $display("FAIL hold_%0d: valid=%b rdy=%b cnt=%0d lane0=%h want 1 0 3 00014000", i, out_valid, in_ready, out_count, lane(out_vec, 0));
      else pass_cnt++;
    end
    start = 1'b0;
    release_out();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || lane(out_vec, 0) !== 32'h00014000) $display("FAIL release: valid=%b busy=%b lane0=%h want 0 0 00014000", out_valid, busy, lane(out_vec, 0));
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_start(5'd1);
    xfer(32'h7FFFFFFF, 32'h00000001);
    total_cnt++;
    if (lane(out_vec, 0) !== 32'h7FFFFFFF || sat_flag !== 1'b1 || out_valid !== 1'b1 || out_count !== 5'd1) $display("FAIL sat_result: lane0=%h sat=%b valid=%b cnt=%0d want 7fffffff 1 1 1", lane(out_vec, 0), sat_flag, out_valid, out_count);
    else pass_cnt++;
    step();
    release_out();
    total_cnt++;
    if (sat_flag !== 1'b1 || busy !== 1'b0) $display("FAIL sat_sticky: sat=%b busy=%b want 1 0", sat_flag, busy);
    else pass_cnt++;
    do_start(5'd2);
    total_cnt++;
    if (sat_flag !== 1'b0 || out_vec !== '0) $display("FAIL sat_clear: sat=%b lane0=%h want 0 0", sat_flag, lane(out_vec, 0));
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      in_valid = pat[3-i];
      in_sum   = (i == 0) ? 32'h00000005 : (i == 3) ? 32'h00008000 : 32'h12345678;
      in_bias  = (i == 3) ? 32'h80008000 : 32'h0;
      step();
      if (i == 2) begin
        total_cnt++;
        if (out_count !== 5'd1 || lane(out_vec, 1) !== 32'h0) $display("FAIL gap_hold: cnt=%0d lane1=%h want 1 0", out_count, lane(out_vec, 1));
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || lane(out_vec, 0) !== 32'h5 || lane(nr_out_vec, 1) !== 32'h0) $display("FAIL gap_result: valid=%b lane0=%h nrlane1=%h want 1 5 0", out_valid, lane(out_vec, 0), lane(nr_out_vec, 1));
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_count_zero();
    do_start(5'd0);
    for (int k = 0; k < 16; k++) begin
      xfer(32'(k), 32'h0);
      if (k == 14) begin
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL cnt0_early: valid=%b want 0", out_valid);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (out_valid !== 1'b1 || out_count !== 5'd16 || lane(out_vec, 15) !== 32'd15 || lane(out_vec, 7) !== 32'd7) $display("FAIL cnt0_done: valid=%b cnt=%0d lane15=%h want 1 16 f", out_valid, out_count, lane(out_vec, 15));
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_reset_mid();
    do_start(5'd4);
    xfer(32'h00000001, 32'h0);
    xfer(32'h00000002, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, busy, sat_flag, out_count} !== 9'd0 || out_vec !== '0) $display("FAIL reset_mid: ctrl=%b lane0=%h want 0 0", {out_valid, in_ready, busy, sat_flag, out_count}, lane(out_vec, 0));
    else pass_cnt++;
    do_start(5'd2);
    xfer(32'h00000011, 32'h0);
    xfer(32'h00000022, 32'h0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_count !== 5'd2 || lane(out_vec, 0) !== 32'h11 || lane(out_vec, 1) !== 32'h22 || out_vec[MN*N-1:2*N] !== '0) $display("FAIL reset_restart: valid=%b cnt=%0d lanes=%h %h want 1 2 11 22", out_valid, out_count, lane(out_vec, 0), lane(out_vec, 1));
    else pass_cnt++;
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_hold();
    test_saturation();
    test_gaps();
    test_count_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
